tdc_ctrl: RTL and testbench
===========================

# tdc_ctrl

Sequencer and decoder for the ADPLL time-to-digital converter. It enables the TDC delay line, waits for it to settle, and calibrates the DCO period in delay-tap units by averaging edge spacing. It then decodes the per-reference-cycle thermometer snapshot captured by the TDC flop bank into a fractional phase word for the digital loop filter. It runs on the reference clock and sits between the TDC sampling flops and the phase detector/loop filter.

## Interface
Parameters:
- TDC_N, 64: number of delay taps / sampled flops.
- AVG_LOG2, 3: calibration averages 2^AVG_LOG2 valid measurements.
- WARMUP, 8: cycles `tdc_en` must be high before any sample is trusted.
- PERIOD_INIT, 2*TDC_N-2: `period_avg` value after reset.

Ports (PW = $clog2(TDC_N)+1):
- clk  in  1  reference clock (FREF); all state on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  level request to run the TDC.
- cal_start  in  1  one-cycle pulse requesting a (re)calibration.
- tdc_q  in  TDC_N  sampled delay-line code; bit i is tap i.
- tdc_en  out  1  enables the delay line.
- busy  out  1  high in WARMUP or CAL.
- cal_done  out  1  one-cycle pulse when `period_avg` is updated.
- period_avg  out  PW  averaged DCO period in taps.
- rise_pos, fall_pos  out  PW  decoded edge tap indices.
- phase_out  out  PW  fractional phase in taps, 0..period_avg-1.
- valid  out  1  the outputs above belong to a RUN sample.
- err_noedge  out  1  the sample had no edge; qualified by `valid`.

## Operation
- FSM states: IDLE, WARMUP, CAL, RUN. After reset the state is IDLE.
- IDLE to WARMUP when `en`=1. `tdc_en` is 1 in every state except IDLE.
- WARMUP: counts WARMUP cycles.
  - Goes to CAL if a calibration is pending (a `cal_start` arrived since the last CAL, or no calibration has run since reset).
  - Otherwise goes to RUN.
- CAL: accumulates 2*|fall_pos-rise_pos| for samples where both edges are found. Samples missing an edge are not counted.
  - After 2^AVG_LOG2 counted samples: `period_avg` = acc >> AVG_LOG2, `cal_done` pulses, state goes to RUN.
- RUN: every decoded sample produces `valid`=1.
- `cal_start` in RUN goes to CAL next cycle and clears the accumulator; no warmup is repeated.
- `cal_start` in WARMUP sets the pending flag.
- `en`=0 in any state goes to IDLE next cycle. This aborts CAL without updating `period_avg`, and pending calibration is retained.
- Decode: scan from tap 1 upward.
  - rise = lowest i with q[i-1]=0, q[i]=1.
  - fall = lowest i with q[i-1]=1, q[i]=0.
  - A position that is not found reads as 0.
- Phase: if rise is found, `phase_out` = rise_pos.
  - Else if fall is found, `phase_out` = fall_pos + (period_avg>>1), minus period_avg if the result is ≥ period_avg.
  - Else `err_noedge`=1 and `phase_out` holds its previous value.
- Arithmetic: unsigned PW bits. The accumulator is PW+AVG_LOG2 bits, so it never overflows.

## Timing
- Pipeline: `tdc_q` is registered at edge k and decoded at edge k+1. Outputs are valid after edge k+2, with 2-cycle latency and full throughput.
- `valid` is high only for samples captured while in RUN. Samples in flight when leaving RUN are dropped.
- Reset values:
  - `tdc_en`, `busy`, `cal_done`, `valid`, `err_noedge` = 0.
  - `rise_pos`, `fall_pos`, `phase_out` = 0.
  - `period_avg` = PERIOD_INIT.
- `cal_done` and the new `period_avg` appear on the same edge as the CAL to RUN transition. The first RUN sample uses the new value.
- Reset mid-operation: immediate return to reset values. The pending flag is set again, since no calibration has run since reset.

## Structure
- `tdc_pkg`: state enum type, PW function/localparam, and the edge-finder function.
- One sub-module, `tdc_edge_dec`. It is combinational between two registers, with input the registered code and outputs rise/fall positions plus found flags. It is instantiated once in the decode stage.

## Test plan
Settings for all scenarios: TDC_N=16, AVG_LOG2=2, WARMUP=4.
- Reset then `en`=1: `tdc_en` rises next cycle, `busy`=1 for 4 warmup cycles plus CAL. Feed `tdc_q`=0x01F8 (rise 3, fall 9): after 4 counted samples `cal_done` pulses and `period_avg`=12.
- RUN with `tdc_q`=0x01F8: two cycles later `valid`=1, `rise_pos`=3, `fall_pos`=9, `phase_out`=3.
- RUN with `tdc_q`=0xFC00 then 0x003F (fall at 6, no rise): `phase_out`=10 for the first, then 0 (6+6=12 wraps to 0).
- `tdc_q`=0x0000 and 0xFFFF in RUN: `valid`=1, `err_noedge`=1, `phase_out` holds its last value. The same samples in CAL are not counted, and `cal_done` is delayed accordingly.
- `cal_start` in RUN, then `en`=0 after 2 CAL samples: IDLE next cycle and `period_avg` unchanged. On re-enable, WARMUP then CAL runs.
- Assert `rst_n` low asynchronously mid-CAL: all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/tdc_pkg.sv
// -----------------------------------------------------------------------------
// tdc_pkg
// Shared types and helpers for the TDC controller:
//   tdc_state_e  : controller FSM states
//   tdc_pw()     : width of a tap index / period word for an N-tap line
//   find_edge()  : lowest tap index i >= 1 where the sampled code steps
//                  0->1 (rising) or 1->0 (falling); -1 when there is none
// -----------------------------------------------------------------------------
package tdc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WARMUP = 2'd1,
        ST_CAL    = 2'd2,
        ST_RUN    = 2'd3
    } tdc_state_e;

    // Widest delay line the edge finder can scan.
    localparam int TDC_MAX = 256;

    function automatic int tdc_pw(input int n);
        return $clog2(n) + 1;
    endfunction

    // Only taps below n take part; the code is zero-extended to TDC_MAX.
    function automatic int find_edge(input logic [TDC_MAX-1:0] q,
                                     input int                 n,
                                     input logic               rising);
        int pos;
        pos = -1;
        for (int i = 1; i < TDC_MAX; i++) begin
            if (pos < 0 && i < n && q[i-1] == !rising && q[i] == rising) begin
                pos = i;
            end
        end
        return pos;
    endfunction

endpackage

// File: rtl/tdc_edge_dec.sv
// -----------------------------------------------------------------------------
// tdc_edge_dec
// Combinational thermometer-edge decoder, placed between the code register
// and the decode register of tdc_ctrl.
// Ports:
//   q          in  TDC_N  registered delay-line code, bit i is tap i
//   rise_pos   out PW     lowest tap with q[i-1]=0, q[i]=1 (0 if none)
//   fall_pos   out PW     lowest tap with q[i-1]=1, q[i]=0 (0 if none)
//   rise_found out 1      a rising step exists
//   fall_found out 1      a falling step exists
// -----------------------------------------------------------------------------
module tdc_edge_dec
    import tdc_pkg::*;
#(
    parameter int TDC_N = 64,
    parameter int PW    = tdc_pw(TDC_N)
) (
    input  logic [TDC_N-1:0] q,
    output logic [PW-1:0]    rise_pos,
    output logic [PW-1:0]    fall_pos,
    output logic             rise_found,
    output logic             fall_found
);

    logic [TDC_MAX-1:0] q_ext;
    int                 rise_idx;
    int                 fall_idx;

    always_comb begin
        q_ext            = '0;
        q_ext[TDC_N-1:0] = q;
        rise_idx         = find_edge(q_ext, TDC_N, 1'b1);
        fall_idx         = find_edge(q_ext, TDC_N, 1'b0);
        rise_found       = (rise_idx > 0);
        fall_found       = (fall_idx > 0);
        rise_pos         = rise_found ? PW'(rise_idx) : '0;
        fall_pos         = fall_found ? PW'(fall_idx) : '0;
    end

endmodule

// File: rtl/tdc_ctrl.sv
// -----------------------------------------------------------------------------
// tdc_ctrl
// Sequencer and decoder for the ADPLL time-to-digital converter. Enables the
// delay line, waits WARMUP cycles, calibrates the DCO period in taps by
// averaging 2*|fall-rise| over 2^AVG_LOG2 good samples, then turns each
// reference-cycle snapshot into a fractional phase word.
// Ports:
//   clk        in  1      reference clock, rising edge
//   rst_n      in  1      asynchronous active-low reset
//   en         in  1      level request to run the TDC
//   cal_start  in  1      one-cycle recalibration request
//   tdc_q      in  TDC_N  sampled delay-line code
//   tdc_en     out 1      delay-line enable (all states but IDLE)
//   busy       out 1      WARMUP or CAL in progress
//   cal_done   out 1      pulse when period_avg is updated
//   period_avg out PW     averaged DCO period in taps
//   rise_pos   out PW     decoded rising-edge tap
//   fall_pos   out PW     decoded falling-edge tap
//   phase_out  out PW     fractional phase, 0..period_avg-1
//   valid      out 1      outputs belong to a RUN sample
//   err_noedge out 1      sample had no edge (qualified by valid)
// Pipeline: code register (p0) -> decode register (p1) -> outputs.
// -----------------------------------------------------------------------------
module tdc_ctrl
    import tdc_pkg::*;
#(
    parameter int TDC_N       = 64,
    parameter int AVG_LOG2    = 3,
    parameter int WARMUP      = 8,
    parameter int PERIOD_INIT = 2*TDC_N-2,
    localparam int PW         = tdc_pw(TDC_N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             cal_start,
    input  logic [TDC_N-1:0] tdc_q,
    output logic             tdc_en,
    output logic             busy,
    output logic             cal_done,
    output logic [PW-1:0]    period_avg,
    output logic [PW-1:0]    rise_pos,
    output logic [PW-1:0]    fall_pos,
    output logic [PW-1:0]    phase_out,
    output logic             valid,
    output logic             err_noedge
);

    localparam int ACC_W = PW + AVG_LOG2;
    localparam int WC_W  = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam int CC_W  = AVG_LOG2 + 1;

    localparam logic [WC_W-1:0] WARM_LAST  = WC_W'(WARMUP - 1);
    localparam logic [CC_W-1:0] CAL_LAST   = CC_W'((1 << AVG_LOG2) - 1);
    localparam logic [PW-1:0]   PERIOD_RST = PW'(PERIOD_INIT);

    // Fold a fall-referenced phase back into 0..period-1.
    function automatic logic [PW-1:0] wrap_phase(input logic [PW-1:0] fall,
                                                 input logic [PW-1:0] period);
        logic [PW:0] sum;
        sum = {1'b0, fall} + {1'b0, (period >> 1)};
        if (sum >= {1'b0, period}) begin
            sum = sum - {1'b0, period};
        end
        return sum[PW-1:0];
    endfunction

    // Two edge spacings form one full DCO period.
    function automatic logic [PW:0] twice_span(input logic [PW-1:0] a,
                                               input logic [PW-1:0] b);
        logic [PW-1:0] d;
        d = (a > b) ? (a - b) : (b - a);
        return {d, 1'b0};
    endfunction

    tdc_state_e        state;
    tdc_state_e        next_state;
    logic [WC_W-1:0]   warm_cnt;
    logic              cal_pend;
    logic [CC_W-1:0]   cal_cnt;
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  acc_next;
    logic              cal_sample;
    logic              cal_complete;
    logic              out_load;

    logic [TDC_N-1:0]  q_p0;
    logic              vld_p0;
    logic              cal_p0;

    logic [PW-1:0]     rise_dec;
    logic [PW-1:0]     fall_dec;
    logic              rise_fnd;
    logic              fall_fnd;

    logic [PW-1:0]     rise_p1;
    logic [PW-1:0]     fall_p1;
    logic              rise_fnd_p1;
    logic              fall_fnd_p1;
    logic              vld_p1;

    assign tdc_en = (state != ST_IDLE);
    assign busy   = (state == ST_WARMUP) || (state == ST_CAL);

    // A CAL sample counts only if it was captured in CAL and has both edges.
    assign cal_sample   = (state == ST_CAL) && cal_p0 && rise_fnd && fall_fnd;
    assign acc_next     = acc + ACC_W'(twice_span(fall_dec, rise_dec));
    assign cal_complete = cal_sample && en && (cal_cnt == CAL_LAST);
    assign out_load     = vld_p1 && (state == ST_RUN);

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (en) next_state = ST_WARMUP;
            end
            ST_WARMUP: begin
                if (warm_cnt == WARM_LAST) begin
                    next_state = (cal_pend || cal_start) ? ST_CAL : ST_RUN;
                end
            end
            ST_CAL: begin
                if (cal_complete) next_state = ST_RUN;
            end
            ST_RUN: begin
                if (cal_start) next_state = ST_CAL;
            end
            default: next_state = ST_IDLE;
        endcase
        // Dropping en wins everywhere and aborts a calibration in progress.
        if (!en) next_state = ST_IDLE;
    end

    // Control state and sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            warm_cnt   <= '0;
            cal_pend   <= 1'b1;
            cal_cnt    <= '0;
            period_avg <= PERIOD_RST;
            cal_done   <= 1'b0;
        end else begin
            state    <= next_state;
            warm_cnt <= (state == ST_WARMUP) ? warm_cnt + WC_W'(1) : '0;
            if (cal_complete) begin
                cal_pend <= 1'b0;
            end else if (cal_start && state != ST_CAL) begin
                cal_pend <= 1'b1;
            end
            if (state != ST_CAL) begin
                cal_cnt <= '0;
            end else if (cal_sample) begin
                cal_cnt <= cal_cnt + CC_W'(1);
            end
            if (cal_complete) begin
                period_avg <= acc_next[ACC_W-1:AVG_LOG2];
            end
            cal_done <= cal_complete;
        end
    end

    // Accumulator restarts on every entry into CAL.
    always_ff @(posedge clk) begin
        if (state != ST_CAL) begin
            acc <= '0;
        end else if (cal_sample) begin
            acc <= acc_next;
        end
    end

    // Stage p0: capture the delay-line code
    always_ff @(posedge clk) begin
        q_p0 <= tdc_q;
    end

    tdc_edge_dec #(
        .TDC_N (TDC_N),
        .PW    (PW)
    ) u_dec (
        .q          (q_p0),
        .rise_pos   (rise_dec),
        .fall_pos   (fall_dec),
        .rise_found (rise_fnd),
        .fall_found (fall_fnd)
    );

    // Stage p1: register the decoded edges
    always_ff @(posedge clk) begin
        rise_p1     <= rise_dec;
        fall_p1     <= fall_dec;
        rise_fnd_p1 <= rise_fnd;
        fall_fnd_p1 <= fall_fnd;
    end

    // Sample tags; anything in flight when RUN is left is dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            cal_p0 <= 1'b0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p0 <= (state == ST_RUN);
            cal_p0 <= (state == ST_CAL);
            vld_p1 <= vld_p0 && (state == ST_RUN);
        end
    end

    // Output stage: phase word
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid      <= 1'b0;
            err_noedge <= 1'b0;
            rise_pos   <= '0;
            fall_pos   <= '0;
            phase_out  <= '0;
        end else begin
            valid <= out_load;
            if (out_load) begin
                rise_pos   <= rise_p1;
                fall_pos   <= fall_p1;
                err_noedge <= !rise_fnd_p1 && !fall_fnd_p1;
                if (rise_fnd_p1) begin
                    phase_out <= rise_p1;
                end else if (fall_fnd_p1) begin
                    phase_out <= wrap_phase(fall_p1, period_avg);
                end
            end else begin
                err_noedge <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tdc_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tdc_ctrl
// Directed testbench for tdc_ctrl with TDC_N=16, AVG_LOG2=2, WARMUP=4.
// -----------------------------------------------------------------------------
module tb_tdc_ctrl;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        cal_start;
    logic [15:0] tdc_q;
    logic        tdc_en;
    logic        busy;
    logic        cal_done;
    logic [4:0]  period_avg;
    logic [4:0]  rise_pos;
    logic [4:0]  fall_pos;
    logic [4:0]  phase_out;
    logic        valid;
    logic        err_noedge;

    int n_tests;
    int n_fail;

    tdc_ctrl #(
        .TDC_N    (16),
        .AVG_LOG2 (2),
        .WARMUP   (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .cal_start  (cal_start),
        .tdc_q      (tdc_q),
        .tdc_en     (tdc_en),
        .busy       (busy),
        .cal_done   (cal_done),
        .period_avg (period_avg),
        .rise_pos   (rise_pos),
        .fall_pos   (fall_pos),
        .phase_out  (phase_out),
        .valid      (valid),
        .err_noedge (err_noedge)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; en = 1'b0; cal_start = 1'b0; tdc_q = 16'h0000;
        tick; tick;
        n_tests++;
        if (tdc_en !== 1'b0 || busy !== 1'b0 || cal_done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: tdc_en=%b busy=%b cal_done=%b expected 0 0 0", tdc_en, busy, cal_done);
        end
        n_tests++;
        if (valid !== 1'b0 || err_noedge !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_flags: valid=%b err=%b expected 0 0", valid, err_noedge);
        end
        n_tests++;
        if (rise_pos !== 5'd0 || fall_pos !== 5'd0 || phase_out !== 5'd0) begin
            n_fail++;
            $display("FAIL reset_pos: rise=%0d fall=%0d phase=%0d expected 0 0 0", rise_pos, fall_pos, phase_out);
        end
        n_tests++;
        if (period_avg !== 5'd30) begin
            n_fail++;
            $display("FAIL reset_period: got %0d expected 30", period_avg);
        end
        rst_n = 1'b1;
        tick;
        n_tests++;
        if (tdc_en !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_no_en: tdc_en=%b expected 0", tdc_en);
        end
    endtask

    // en is raised here; cal_done is expected on the 10th edge after that
    // (1 to WARMUP, 4 warmup cycles, 1 capture, 4 counted samples).
    task automatic cal_from_enable(input string name, input logic [4:0] exp_period);
        int cyc;
        logic seen;
        int busy_bad;
        en = 1'b1;
        tick;
        cyc = 1; seen = 1'b0; busy_bad = 0;
        n_tests++;
        if (tdc_en !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s_enable: tdc_en=%b busy=%b expected 1 1", name, tdc_en, busy);
        end
        while (!seen && cyc < 40) begin
            if (busy !== 1'b1) busy_bad++;
            tick;
            cyc++;
            if (cal_done === 1'b1) seen = 1'b1;
        end
        n_tests++;
        if (!seen || cyc != 10) begin
            n_fail++;
            $display("FAIL %s_cal_done: seen=%b at cycle %0d expected cycle 10", name, seen, cyc);
        end
        n_tests++;
        if (busy_bad != 0) begin
            n_fail++;
            $display("FAIL %s_busy: busy low %0d times before cal_done, expected 0", name, busy_bad);
        end
        n_tests++;
        if (period_avg !== exp_period || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_period: period=%0d busy=%b expected %0d 0", name, period_avg, busy, exp_period);
        end
    endtask

    task automatic test_first_cal;
        tdc_q = 16'h01F8;
        cal_from_enable("first_cal", 5'd12);
    endtask

    task automatic test_run_decode;
        tick;
        n_tests++;
        if (cal_done !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_lat1: cal_done=%b valid=%b expected 0 0", cal_done, valid);
        end
        tick;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_lat2: valid=%b expected 0", valid);
        end
        tick;
        n_tests++;
        if (valid !== 1'b1 || rise_pos !== 5'd3 || fall_pos !== 5'd9 || phase_out !== 5'd3 || err_noedge !== 1'b0) begin
            n_fail++;
            $display("FAIL run_decode: valid=%b rise=%0d fall=%0d phase=%0d err=%b expected 1 3 9 3 0",
                     valid, rise_pos, fall_pos, phase_out, err_noedge);
        end
    endtask

    task automatic test_fall_only;
        tdc_q = 16'hFC00; tick;
        tdc_q = 16'h003F; tick;
        tick;
        n_tests++;
        if (valid !== 1'b1 || rise_pos !== 5'd10 || fall_pos !== 5'd0 || phase_out !== 5'd10) begin
            n_fail++;
            $display("FAIL rise_only_fc00: valid=%b rise=%0d fall=%0d phase=%0d expected 1 10 0 10",
                     valid, rise_pos, fall_pos, phase_out);
        end
        tick;
        n_tests++;
        if (valid !== 1'b1 || rise_pos !== 5'd0 || fall_pos !== 5'd6 || phase_out !== 5'd0 || err_noedge !== 1'b0) begin
            n_fail++;
            $display("FAIL fall_wrap_003f: valid=%b rise=%0d fall=%0d phase=%0d err=%b expected 1 0 6 0 0",
                     valid, rise_pos, fall_pos, phase_out, err_noedge);
        end
    endtask

    task automatic test_noedge_run;
        tdc_q = 16'h01F8; tick;
        tdc_q = 16'h0000; tick;
        tdc_q = 16'hFFFF; tick;
        tick;
        n_tests++;
        if (valid !== 1'b1 || err_noedge !== 1'b1 || phase_out !== 5'd3 || rise_pos !== 5'd0 || fall_pos !== 5'd0) begin
            n_fail++;
            $display("FAIL noedge_0000: valid=%b err=%b phase=%0d rise=%0d fall=%0d expected 1 1 3 0 0",
                     valid, err_noedge, phase_out, rise_pos, fall_pos);
        end
        tick;
        n_tests++;
        if (valid !== 1'b1 || err_noedge !== 1'b1 || phase_out !== 5'd3) begin
            n_fail++;
            $display("FAIL noedge_ffff: valid=%b err=%b phase=%0d expected 1 1 3", valid, err_noedge, phase_out);
        end
        tdc_q = 16'h003F;
        tick; tick; tick;
        n_tests++;
        if (valid !== 1'b1 || err_noedge !== 1'b0 || phase_out !== 5'd0) begin
            n_fail++;
            $display("FAIL noedge_recover: valid=%b err=%b phase=%0d expected 1 0 0", valid, err_noedge, phase_out);
        end
    endtask

    task automatic test_cal_skip;
        logic [15:0] seq [6];
        int early;
        seq[0] = 16'h0000; seq[1] = 16'h0FF0; seq[2] = 16'hFFFF;
        seq[3] = 16'h0FF0; seq[4] = 16'h0FF0; seq[5] = 16'h0FF0;
        early = 0;
        tdc_q = 16'h0000; cal_start = 1'b1;
        tick;
        cal_start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL recal_enter: busy=%b expected 1", busy);
        end
        for (int i = 0; i < 6; i++) begin
            tdc_q = seq[i];
            tick;
            if (i == 0) begin
                n_tests++;
                if (valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL recal_drop: valid=%b expected 0", valid);
                end
            end
            if (cal_done !== 1'b0) early++;
        end
        n_tests++;
        if (early != 0 || period_avg !== 5'd12) begin
            n_fail++;
            $display("FAIL recal_skip: early cal_done %0d period=%0d expected 0 12", early, period_avg);
        end
        tick;
        n_tests++;
        if (cal_done !== 1'b1 || period_avg !== 5'd16 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL recal_done: cal_done=%b period=%0d busy=%b expected 1 16 0", cal_done, period_avg, busy);
        end
        tdc_q = 16'h000F;
        tick;
        tick;
        n_tests++;
        if (valid !== 1'b0) begin
            n_fail++;
            $display("FAIL recal_first_lat: valid=%b expected 0", valid);
        end
        tick;
        n_tests++;
        if (valid !== 1'b1 || fall_pos !== 5'd4 || phase_out !== 5'd12) begin
            n_fail++;
            $display("FAIL new_period_phase: valid=%b fall=%0d phase=%0d expected 1 4 12", valid, fall_pos, phase_out);
        end
    endtask

    task automatic test_abort;
        tdc_q = 16'h01F8; cal_start = 1'b1;
        tick;
        cal_start = 1'b0;
        tick; tick; tick;
        en = 1'b0;
        tick;
        n_tests++;
        if (tdc_en !== 1'b0 || busy !== 1'b0 || cal_done !== 1'b0 || valid !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_idle: tdc_en=%b busy=%b cal_done=%b valid=%b expected 0 0 0 0",
                     tdc_en, busy, cal_done, valid);
        end
        n_tests++;
        if (period_avg !== 5'd16) begin
            n_fail++;
            $display("FAIL abort_period: got %0d expected 16", period_avg);
        end
        tick; tick;
        cal_from_enable("abort_resume", 5'd12);
    endtask

    task automatic test_no_pending;
        int done_seen;
        done_seen = 0;
        en = 1'b0;
        tick;
        en = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick;
            if (cal_done === 1'b1) done_seen++;
            if (i == 4) begin
                n_tests++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL nopend_warmup: busy=%b expected 1", busy);
                end
            end
            if (i == 5) begin
                n_tests++;
                if (busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL nopend_run: busy=%b expected 0", busy);
                end
            end
        end
        n_tests++;
        if (done_seen != 0 || valid !== 1'b1 || rise_pos !== 5'd3) begin
            n_fail++;
            $display("FAIL nopend_outputs: cal_done count %0d valid=%b rise=%0d expected 0 1 3",
                     done_seen, valid, rise_pos);
        end
    endtask

    task automatic test_async_reset;
        cal_start = 1'b1;
        tick;
        cal_start = 1'b0;
        tick; tick;
        n_tests++;
        if (busy !== 1'b1 || tdc_en !== 1'b1) begin
            n_fail++;
            $display("FAIL areset_pre: busy=%b tdc_en=%b expected 1 1", busy, tdc_en);
        end
        #3;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (tdc_en !== 1'b0 || busy !== 1'b0 || cal_done !== 1'b0 || valid !== 1'b0 || err_noedge !== 1'b0) begin
            n_fail++;
            $display("FAIL areset_ctrl: tdc_en=%b busy=%b cal_done=%b valid=%b err=%b expected all 0",
                     tdc_en, busy, cal_done, valid, err_noedge);
        end
        n_tests++;
        if (rise_pos !== 5'd0 || fall_pos !== 5'd0 || phase_out !== 5'd0 || period_avg !== 5'd30) begin
            n_fail++;
            $display("FAIL areset_data: rise=%0d fall=%0d phase=%0d period=%0d expected 0 0 0 30",
                     rise_pos, fall_pos, phase_out, period_avg);
        end
        tick;
        rst_n = 1'b1;
        tdc_q = 16'h0FF0;
        cal_from_enable("post_reset", 5'd16);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset;
        test_first_cal;
        test_run_decode;
        test_fall_only;
        test_noedge_run;
        test_cal_skip;
        test_abort;
        test_no_pending;
        test_async_reset;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
